led_matrix_scan: RTL and testbench

Parametrised row-scanning driver for an LED dot-matrix display, replacing the fixed 8×8 two-pattern scanner. It holds two frame banks with a write port, so host logic can compose the next frame off-screen and swap it in atomically at a frame boundary. It also adds per-row dwell timing, column-scroll mode and blanking. It sits between pattern-generation logic and the matrix row/column pins, clocked by the divided scan clock.

---
 rtl/led_matrix_pkg.sv | 40 ++++
 rtl/led_matrix_bank.sv | 66 ++++++
 rtl/led_matrix_scan.sv | 140 ++++++++++++++
 tb/tb_led_matrix_scan.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg
//   Shared constants and helpers for the LED dot-matrix scanner.
//   - DEFAULT_* : default geometry and timing of the matrix driver.
//   - MAX_COLS  : widest column word the rotate helper handles.
//   - idx_width : bit width for an index or counter over n values (min 1).
//   - rotl      : rotates the low `cols` bits of a word left by `offset`.
package led_matrix_pkg;

  localparam int DEFAULT_ROWS          = 8;
  localparam int DEFAULT_COLS          = 8;
  localparam int DEFAULT_DWELL         = 1;
  localparam int DEFAULT_SCROLL_FRAMES = 4;
  localparam int MAX_COLS              = 64;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit c moves to bit (c + offset) mod cols. Bits at or above `cols` are
  // ignored and return as zero. The caller keeps offset below cols, so one
  // conditional subtract replaces a modulo.
  function automatic logic [MAX_COLS-1:0] rotl(
    input logic [MAX_COLS-1:0] word,
    input int                  offset,
    input int                  cols
  );
    logic [MAX_COLS-1:0] result;
    int                  dst;
    result = '0;
    for (int c = 0; c < MAX_COLS; c++) begin
      if (c < cols) begin
        dst = c + offset;
        if (dst >= cols) dst = dst - cols;
        result[dst] = word[c];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/led_matrix_bank.sv
// led_matrix_bank
//   Two-bank frame store for the matrix scanner. One bank is displayed and the
//   other is hidden. Host writes always land in the hidden bank. A toggle
//   exchanges the two banks at the clock edge.
//   Ports:
//     divided_clk  scan clock
//     rst          synchronous active-high reset; clears both banks, shows bank 0
//     wr_en        write strobe into the bank hidden in this cycle
//     wr_addr      row written; out-of-range rows are ignored
//     wr_data      column pattern for that row
//     toggle       exchange displayed and hidden banks at this edge
//     rd_addr      row to read
//     rd_data      combinational read of the bank that is displayed after this
//                  edge (includes a toggle happening at this edge)
module led_matrix_bank
  import led_matrix_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS,
  parameter int AW   = idx_width(ROWS)
) (
  input  logic            divided_clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  input  logic            toggle,
  input  logic [AW-1:0]   rd_addr,
  output logic [COLS-1:0] rd_data
);

  logic [COLS-1:0] mem [2][ROWS];
  logic            sel;
  logic            addr_ok;

  // The range check is needed only when the address field can encode rows
  // that do not exist.
  if ((2 ** AW) > ROWS) begin : g_addr_chk
    assign addr_ok = int'(wr_addr) < ROWS;
  end else begin : g_addr_full
    assign addr_ok = 1'b1;
  end

  always_ff @(posedge divided_clk) begin
    if (rst) begin
      sel <= 1'b0;
      // NOTE: the banks are cleared on reset because the frame after reset
      // must read dark. A reset like this prevents mapping the store onto
      // block RAM, so it is built from flops.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else begin
      // The bank hidden in this cycle is written, even when a toggle happens
      // at the same edge. The write therefore lands in the frame about to be
      // shown.
      if (wr_en && addr_ok) mem[~sel][wr_addr] <= wr_data;
      if (toggle) sel <= ~sel;
    end
  end

  assign rd_data = mem[sel ^ toggle][rd_addr];

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan
//   Row-scanning driver for a ROWS x COLS LED dot matrix. It uses double-buffered
//   frames with atomic swap at frame boundaries, per-row dwell, column scroll and
//   blanking.
//   Ports:
//     divided_clk  scan clock (only clock)
//     rst          synchronous active-high reset
//     en           scan advance enable; low freezes dwell/row/swap/scroll
//     wr_en        write strobe into the hidden bank
//     wr_addr      row index written
//     wr_data      column pattern written (bit c lights column c)
//     swap_req     request to exchange displayed and hidden banks
//     swap_ack     one-cycle pulse on the edge the swap takes effect
//     scroll_en    rotate displayed columns one step every SCROLL_FRAMES frames
//     blank        force columns dark; the row scan continues
//     row          one-hot active row (registered)
//     column       column drive for the active row (registered with row)
//     frame_start  one-cycle pulse on the edge row returns to row 0
//   COLS must not exceed led_matrix_pkg::MAX_COLS.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS          = DEFAULT_ROWS,
  parameter int COLS          = DEFAULT_COLS,
  parameter int DWELL         = DEFAULT_DWELL,
  parameter int SCROLL_FRAMES = DEFAULT_SCROLL_FRAMES,
  localparam int AW           = idx_width(ROWS)
) (
  input  logic            divided_clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_ack,
  input  logic            scroll_en,
  input  logic            blank,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] column,
  output logic            frame_start
);

  localparam int DW = idx_width(DWELL);
  localparam int OW = idx_width(COLS);
  localparam int FW = idx_width(SCROLL_FRAMES);

  logic [DW-1:0]   dwell_q,   dwell_d;
  logic [AW-1:0]   idx_q,     idx_d;
  logic [OW-1:0]   offset_q,  offset_d;
  logic [FW-1:0]   frame_q,   frame_d;
  logic            pending_q, pending_d;
  logic            advance;
  logic            boundary;
  logic            do_swap;
  logic [COLS-1:0] disp_word;

  always_comb begin
    // NOTE: every variable gets a default before any branch. This way no path
    // leaves it unassigned, and no latch is inferred.
    dwell_d   = dwell_q;
    idx_d     = idx_q;
    offset_d  = offset_q;
    frame_d   = frame_q;
    pending_d = pending_q;

    advance  = en && (dwell_q == DW'(DWELL - 1));
    boundary = advance && (idx_q == AW'(ROWS - 1));
    // A request in the boundary cycle itself still makes this swap.
    do_swap  = boundary && (pending_q || swap_req);

    if (advance) begin
      dwell_d = '0;
      idx_d   = boundary ? '0 : idx_q + AW'(1);
    end else if (en) begin
      dwell_d = dwell_q + DW'(1);
    end

    // The pending flag latches even when en=0. Repeated requests do nothing extra.
    if (do_swap) pending_d = 1'b0;
    else if (swap_req) pending_d = 1'b1;

    if (!scroll_en) begin
      offset_d = '0;
      frame_d  = '0;
    end else if (boundary) begin
      if (frame_q == FW'(SCROLL_FRAMES - 1)) begin
        frame_d  = '0;
        offset_d = (offset_q == OW'(COLS - 1)) ? '0 : offset_q + OW'(1);
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // The read uses the next row index and post-swap bank. The registered column
  // therefore matches the registered row.
  led_matrix_bank #(
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW)
  ) u_bank (
    .divided_clk (divided_clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .toggle      (do_swap),
    .rd_addr     (idx_d),
    .rd_data     (disp_word)
  );

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge divided_clk) begin
    if (rst) begin
      dwell_q     <= '0;
      idx_q       <= '0;
      offset_q    <= '0;
      frame_q     <= '0;
      pending_q   <= 1'b0;
      row         <= ROWS'(1);
      column      <= '0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      offset_q    <= offset_d;
      frame_q     <= frame_d;
      pending_q   <= pending_d;
      row         <= ROWS'(1) << idx_d;
      column      <= blank ? '0
                           : COLS'(rotl(MAX_COLS'(disp_word), int'(offset_d), COLS));
      swap_ack    <= do_swap;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan
//   Directed bench for led_matrix_scan with 8x8 geometry.
//   dut_a: DWELL=2, SCROLL_FRAMES=4. Used for scan, swap, collision, blank/enable and reset.
//   dut_b: DWELL=1, SCROLL_FRAMES=1. Used for scroll.
//   Both instances share every input. Outputs are sampled 1 time unit after the rising edge.
module tb_led_matrix_scan;

  logic       clk = 1'b0;
  logic       rst, en, wr_en, swap_req, scroll_en, blank;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] row_a, column_a, row_b, column_b;
  logic       swap_ack_a, frame_start_a, swap_ack_b, frame_start_b;

  logic [17:0] got, want;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] pat [8] = '{8'h1E, 8'h21, 8'h41, 8'h82, 8'h82, 8'h41, 8'h21, 8'h1E};

  always #5 clk = ~clk;

  led_matrix_scan #(.ROWS(8), .COLS(8), .DWELL(2), .SCROLL_FRAMES(4)) dut_a (
    .divided_clk (clk),
    .rst         (rst),
    .en          (en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack_a),
    .scroll_en   (scroll_en),
    .blank       (blank),
    .row         (row_a),
    .column      (column_a),
    .frame_start (frame_start_a)
  );

  led_matrix_scan #(.ROWS(8), .COLS(8), .DWELL(1), .SCROLL_FRAMES(1)) dut_b (
    .divided_clk (clk),
    .rst         (rst),
    .en          (en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack_b),
    .scroll_en   (scroll_en),
    .blank       (blank),
    .row         (row_b),
    .column      (column_b),
    .frame_start (frame_start_b)
  );

  function automatic logic [7:0] onehot(input int i);
    return 8'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; swap_req = 1'b0;
    scroll_en = 1'b0; blank = 1'b0; wr_addr = '0; wr_data = '0;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  // Row sequence for DWELL=2 with column dark. frame_start every 16 cycles.
  task automatic test_reset_scan();
    do_reset();
    got  = {row_a, column_a, swap_ack_a, frame_start_a};
    want = {8'h01, 8'h00, 1'b0, 1'b0};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset row/col/ack/fs got %h want %h", got, want);
    end
    for (int k = 1; k <= 33; k++) begin
      tick();
      got  = {row_a, column_a, swap_ack_a, frame_start_a};
      want = {onehot((cyc / 2) % 8), 8'h00, 1'b0, (cyc % 16 == 0)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL scan cyc=%0d got %h want %h", cyc, got, want);
      end
    end
  endtask

  // Fill the hidden bank and request a swap mid-frame. The pattern appears
  // only from the next wrap.
  task automatic test_write_swap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = pat[i];
      tick();
      n_tests++;
      if (column_a !== 8'h00) begin
        n_fail++;
        $display("FAIL early_write cyc=%0d got %h want 00", cyc, column_a);
      end
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    while (cyc < 15) begin
      tick();
      got  = {row_a, column_a, swap_ack_a, frame_start_a};
      want = {onehot((cyc / 2) % 8), 8'h00, 1'b0, 1'b0};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pre_swap cyc=%0d got %h want %h", cyc, got, want);
      end
    end
    for (int k = 16; k <= 31; k++) begin
      tick();
      got  = {row_a, column_a, swap_ack_a, frame_start_a};
      want = {onehot((cyc / 2) % 8), pat[(cyc / 2) % 8], (cyc == 16), (cyc == 16)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL swap_show cyc=%0d got %h want %h", cyc, got, want);
      end
    end
  endtask

  // Swap request and write in the same boundary cycle (cycle 32). The write
  // lands in the bank shown next.
  task automatic test_collision();
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hD6;
    tick();
    swap_req = 1'b0; wr_en = 1'b0;
    got  = {row_a, column_a, swap_ack_a, frame_start_a};
    want = {8'h01, 8'h00, 1'b1, 1'b1};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL collide_edge cyc=%0d got %h want %h", cyc, got, want);
    end
  endtask

  // Frame 32..47 shows bank 0 (only row 3 = D6). A request is held over
  // cycles 40..45, and exactly one ack comes at 48.
  task automatic test_back_to_back();
    int acks;
    acks = 0;
    for (int k = 33; k <= 63; k++) begin
      swap_req = (k >= 40 && k <= 45);
      tick();
      if (swap_ack_a === 1'b1) acks++;
      got = {row_a, column_a, swap_ack_a, frame_start_a};
      if (cyc < 48)
        want = {onehot((cyc / 2) % 8), ((cyc / 2) % 8 == 3) ? 8'hD6 : 8'h00, 1'b0, 1'b0};
      else
        want = {onehot((cyc / 2) % 8), pat[(cyc / 2) % 8], (cyc == 48), (cyc == 48)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL collide_frame cyc=%0d got %h want %h", cyc, got, want);
      end
    end
    swap_req = 1'b0;
    n_tests++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL single_ack count got %0d want 1", acks);
    end
  endtask

  // Blank for one mid-row cycle, then freeze with en=0 for 5 edges (blanked
  // on the last two), then resume with the remaining dwell.
  task automatic test_blank_enable();
    logic [17:0] exp_seq [5];
    exp_seq[0] = {8'h01, 8'h1E, 1'b0, 1'b1};  // cyc 64: wrap
    exp_seq[1] = {8'h01, 8'h1E, 1'b0, 1'b0};  // cyc 65
    exp_seq[2] = {8'h02, 8'h21, 1'b0, 1'b0};  // cyc 66
    exp_seq[3] = {8'h02, 8'h00, 1'b0, 1'b0};  // cyc 67: blank
    exp_seq[4] = {8'h04, 8'h00, 1'b0, 1'b0};  // cyc 68: blank, row advances
    for (int i = 0; i < 5; i++) begin
      blank = (i == 3 || i == 4);
      tick();
      got = {row_a, column_a, swap_ack_a, frame_start_a};
      n_tests++;
      if (got !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL blank cyc=%0d got %h want %h", cyc, got, exp_seq[i]);
      end
    end
    blank = 1'b0;
    tick();  // cyc 69
    tick();  // cyc 70: row 3 entered
    got  = {row_a, column_a, swap_ack_a, frame_start_a};
    want = {8'h08, 8'h82, 1'b0, 1'b0};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL unblank cyc=%0d got %h want %h", cyc, got, want);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      blank = (i >= 3);
      tick();
      got  = {row_a, column_a, swap_ack_a, frame_start_a};
      want = {8'h08, (i >= 3) ? 8'h00 : 8'h82, 1'b0, 1'b0};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL freeze step=%0d got %h want %h", i, got, want);
      end
    end
    en = 1'b1; blank = 1'b0;
    tick();
    got  = {row_a, column_a, swap_ack_a, frame_start_a};
    want = {8'h08, 8'h82, 1'b0, 1'b0};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL resume_dwell got %h want %h", got, want);
    end
    tick();
    got  = {row_a, column_a, swap_ack_a, frame_start_a};
    want = {8'h10, 8'h82, 1'b0, 1'b0};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL resume_adv got %h want %h", got, want);
    end
  endtask

  // Reset at row 0x10 with a swap pending. There is no stale ack, and both
  // banks read zero.
  task automatic test_reset_mid();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
    got  = {row_a, column_a, swap_ack_a, frame_start_a};
    want = {8'h01, 8'h00, 1'b0, 1'b0};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL mid_reset got %h want %h", got, want);
    end
    for (int k = 1; k <= 47; k++) begin
      swap_req = (k == 17);
      tick();
      got  = {row_a, column_a, swap_ack_a, frame_start_a};
      want = {onehot((cyc / 2) % 8), 8'h00, (cyc == 32), (cyc % 16 == 0)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL post_reset cyc=%0d got %h want %h", cyc, got, want);
      end
    end
    swap_req = 1'b0;
  endtask

  // dut_b: all rows 0x01. Scroll moves the lit column one step per frame and
  // wraps. Dropping scroll_en returns to 0x01.
  task automatic test_scroll();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'h01;
      tick();
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int k = 10; k <= 16; k++) begin
      tick();
      got  = {row_b, column_b, swap_ack_b, frame_start_b};
      want = {onehot(cyc % 8), (cyc == 16) ? 8'h01 : 8'h00, (cyc == 16), (cyc % 8 == 0)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL scroll_swap cyc=%0d got %h want %h", cyc, got, want);
      end
    end
    scroll_en = 1'b1;
    for (int k = 17; k <= 87; k++) begin
      tick();
      got  = {row_b, column_b, swap_ack_b, frame_start_b};
      want = {onehot(cyc % 8), onehot(((cyc - 16) / 8) % 8), 1'b0, (cyc % 8 == 0)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL scroll cyc=%0d got %h want %h", cyc, got, want);
      end
    end
    scroll_en = 1'b0;
    for (int k = 88; k <= 95; k++) begin
      tick();
      got  = {row_b, column_b, swap_ack_b, frame_start_b};
      want = {onehot(cyc % 8), 8'h01, 1'b0, (cyc % 8 == 0)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL scroll_off cyc=%0d got %h want %h", cyc, got, want);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    scroll_en = 1'b0; blank = 1'b0; wr_addr = '0; wr_data = '0;
    test_reset_scan();
    test_write_swap();
    test_collision();
    test_back_to_back();
    test_blank_enable();
    test_reset_mid();
    test_scroll();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
